// File: rtl/deadtime_generator.sv
// deadtime_generator: two-leg bridge gate driver with dead-time insertion and shoot-through fault latch
module deadtime_generator #(
  parameter logic [7:0] DT_MIN  = 8'd10,
  parameter logic [2:0] ILL_MAX = 3'd4
) (
  input  logic       i_clock,
  input  logic       i_RESET,
  input  logic [3:0] i_MOSFET,
  input  logic [7:0] i_deadtime,
  input  logic       i_enable,
  output logic [3:0] o_gate,
  output logic [1:0] o_dead,
  output logic       o_fault
);
  typedef enum logic [2:0] {OFF, DEAD_H, HIGH, DEAD_L, LOW} state_t;
  state_t     state   [2];
  state_t     state_n [2];
  logic [7:0] cnt     [2];
  logic [7:0] cnt_n   [2];
  logic [2:0] ill     [2];
  logic [2:0] ill_n   [2];
  logic [3:0] req;
  logic [3:0] gate_n;
  logic [1:0] dead_n;
  logic [7:0] dt_load;
  logic       fault_n;
  logic       kill;
  assign dt_load = (i_deadtime > DT_MIN) ? i_deadtime : DT_MIN;
  always_comb begin
    fault_n = o_fault;
    for (int n = 0; n < 2; n++) begin
      ill_n[n] = (req[n] & req[n+2]) ? ((ill[n] >= ILL_MAX) ? ill[n] : ill[n] + 3'd1) : 3'd0;
      fault_n  = fault_n | (ill_n[n] >= ILL_MAX);
    end
  end
  // Fault is looked at in its next-cycle value so the gates drop on the same edge it latches
  always_comb begin
    kill    = fault_n | ~i_enable;
    state_n = state;
    cnt_n   = cnt;
    gate_n  = 4'b0000;
    dead_n  = 2'b00;
    for (int n = 0; n < 2; n++) begin
      if (kill || !(req[n] | req[n+2])) begin
        state_n[n] = OFF;
        cnt_n[n]   = 8'd0;
      end else if (req[n] & req[n+2]) begin
        if ((state[n] == DEAD_H || state[n] == DEAD_L) && cnt[n] > 8'd1)
          cnt_n[n] = cnt[n] - 8'd1;
      end else begin
        case (state[n])
          OFF: begin
            state_n[n] = req[n] ? DEAD_H : DEAD_L;
            cnt_n[n]   = dt_load;
          end
          HIGH: if (req[n+2]) begin
            state_n[n] = DEAD_L;
            cnt_n[n]   = dt_load;
          end
          LOW: if (req[n]) begin
            state_n[n] = DEAD_H;
            cnt_n[n]   = dt_load;
          end
          DEAD_H: begin
            state_n[n] = req[n+2] ? LOW : (cnt[n] <= 8'd1) ? HIGH : DEAD_H;
            cnt_n[n]   = (req[n+2] || cnt[n] <= 8'd1) ? 8'd0 : cnt[n] - 8'd1;
          end
          DEAD_L: begin
            state_n[n] = req[n] ? HIGH : (cnt[n] <= 8'd1) ? LOW : DEAD_L;
            cnt_n[n]   = (req[n] || cnt[n] <= 8'd1) ? 8'd0 : cnt[n] - 8'd1;
          end
          default: state_n[n] = OFF;
        endcase
      end
      gate_n[n]   = state_n[n] == HIGH;
      gate_n[n+2] = state_n[n] == LOW;
      dead_n[n]   = state_n[n] == DEAD_H || state_n[n] == DEAD_L;
    end
  end
  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      req     <= 4'b0000;
      state   <= '{default: OFF};
      cnt     <= '{default: 8'd0};
      ill     <= '{default: 3'd0};
      o_gate  <= 4'b0000;
      o_dead  <= 2'b00;
      o_fault <= 1'b0;
    end else begin
      req     <= i_MOSFET;
      state   <= state_n;
      cnt     <= cnt_n;
      ill     <= ill_n;
      o_gate  <= gate_n;
      o_dead  <= dead_n;
      o_fault <= fault_n;
    end
  end
endmodule

// File: tb/tb_deadtime_generator.sv
// tb_deadtime_generator: directed and randomized checks of the dead-time driver against a cycle model
module tb_deadtime_generator;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] mosfet = 4'b0000;
  logic [7:0] dt = 8'd0;
  logic [3:0] o_gate;
  logic [1:0] o_dead;
  logic       o_fault;
  int checks = 0;
  int errors = 0;

  deadtime_generator dut (
    .i_clock(clk), .i_RESET(rst_n), .i_MOSFET(mosfet), .i_deadtime(dt),
    .i_enable(en), .o_gate(o_gate), .o_dead(o_dead), .o_fault(o_fault)
  );

  always #5 clk = ~clk;

  // Model: per leg, the gate currently driven (0 none, 1 high, 2 low), the gate waiting out
  // its dead time, and the cycles of that dead time still to go.
  logic [3:0] m_req;
  logic       m_fault;
  int m_ill [2];
  int m_on [2];
  int m_want [2];
  int m_rem [2];
  int md, mw;
  logic [3:0] m_gate;
  logic [1:0] m_dead;
  assign m_gate = {m_on[1] == 2, m_on[0] == 2, m_on[1] == 1, m_on[0] == 1};
  assign m_dead = {m_want[1] != 0, m_want[0] != 0};

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_req = 4'b0000;
      m_fault = 1'b0;
      for (int n = 0; n < 2; n++) begin
        m_ill[n] = 0; m_on[n] = 0; m_want[n] = 0; m_rem[n] = 0;
      end
    end else begin
      md = (dt > 8'd10) ? int'(dt) : 10;
      for (int n = 0; n < 2; n++) begin
        m_ill[n] = (m_req[n] && m_req[n+2]) ? ((m_ill[n] < 4) ? m_ill[n] + 1 : 4) : 0;
        if (m_ill[n] == 4) m_fault = 1'b1;
      end
      for (int n = 0; n < 2; n++) begin
        mw = m_req[n] ? (m_req[n+2] ? 3 : 1) : (m_req[n+2] ? 2 : 0);
        if (m_fault || !en || mw == 0) begin
          m_on[n] = 0; m_want[n] = 0;
        end else if (mw == 3) begin
          if (m_want[n] != 0 && m_rem[n] > 1) m_rem[n]--;
        end else if (m_want[n] == 0) begin
          if (m_on[n] != mw) begin m_on[n] = 0; m_want[n] = mw; m_rem[n] = md; end
        end else if (m_want[n] != mw) begin
          m_on[n] = mw; m_want[n] = 0;
        end else if (m_rem[n] <= 1) begin
          m_on[n] = mw; m_want[n] = 0;
        end else m_rem[n]--;
      end
      m_req = mosfet;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; mosfet = 4'b1111; dt = 8'd5;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_gate, o_dead, o_fault} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000000", {o_gate, o_dead, o_fault});
    end
    en = 1'b0; mosfet = 4'b0000; rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_gate, o_dead, o_fault} !== 7'b0) begin
      errors++;
      $display("FAIL reset_release: got %b expected 0000000", {o_gate, o_dead, o_fault});
    end
  endtask

  task automatic test_enable_start();
    en = 1'b1; dt = 8'd20; mosfet = 4'b1001;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      checks++;
      if ({o_gate, o_dead, o_fault} !== {m_gate, m_dead, m_fault}) begin
        errors++;
        $display("FAIL start_model cycle %0d: got %b/%b/%b expected %b/%b/%b", i, o_gate, o_dead, o_fault, m_gate, m_dead, m_fault);
      end
      if (i == 21 || i == 22) begin
        checks++;
        if ({o_gate, o_dead} !== ((i == 21) ? 6'b0000_11 : 6'b1001_00)) begin
          errors++;
          $display("FAIL start_timing cycle %0d: gate/dead got %b/%b", i, o_gate, o_dead);
        end
      end
    end
  endtask

  task automatic test_commutation();
    logic [3:0] exp;
    mosfet = 4'b0011;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      checks++;
      if ({o_gate, o_dead, o_fault} !== {m_gate, m_dead, m_fault}) begin
        errors++;
        $display("FAIL commute_model cycle %0d: got %b/%b/%b expected %b/%b/%b", i, o_gate, o_dead, o_fault, m_gate, m_dead, m_fault);
      end
      checks++;
      if (o_gate[1] && o_gate[3]) begin
        errors++;
        $display("FAIL commute_overlap cycle %0d: gate %b", i, o_gate);
      end
      if (i == 1 || i == 2 || i == 21 || i == 22) begin
        exp = (i == 1) ? 4'b1001 : (i == 22) ? 4'b0011 : 4'b0001;
        checks++;
        if (o_gate !== exp) begin
          errors++;
          $display("FAIL commute_timing cycle %0d: gate got %b expected %b", i, o_gate, exp);
        end
      end
    end
  endtask

  task automatic test_clamp();
    int gap = 0;
    dt = 8'd3; mosfet = 4'b1001;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checks++;
      if ({o_gate, o_dead, o_fault} !== {m_gate, m_dead, m_fault}) begin
        errors++;
        $display("FAIL clamp_model cycle %0d: got %b/%b/%b expected %b/%b/%b", i, o_gate, o_dead, o_fault, m_gate, m_dead, m_fault);
      end
      if (!o_gate[1] && !o_gate[3]) gap++;
    end
    checks++;
    if (gap !== 10 || o_gate !== 4'b1001) begin
      errors++;
      $display("FAIL clamp_gap: gap %0d gate %b expected 10 and 1001", gap, o_gate);
    end
  endtask

  task automatic test_abort();
    logic hi_seen = 1'b0;
    mosfet = 4'b1100;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      checks++;
      if ({o_gate, o_dead, o_fault} !== {m_gate, m_dead, m_fault}) begin
        errors++;
        $display("FAIL abort_setup_model cycle %0d: got %b/%b/%b expected %b/%b/%b", i, o_gate, o_dead, o_fault, m_gate, m_dead, m_fault);
      end
    end
    mosfet = 4'b1001;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checks++;
      if ({o_gate, o_dead, o_fault} !== {m_gate, m_dead, m_fault}) begin
        errors++;
        $display("FAIL abort_model cycle %0d: got %b/%b/%b expected %b/%b/%b", i, o_gate, o_dead, o_fault, m_gate, m_dead, m_fault);
      end
      hi_seen |= o_gate[0];
      if (i == 7) mosfet = 4'b1100;
      if (i == 8 || i == 9) begin
        checks++;
        if ({o_gate, o_dead} !== ((i == 8) ? 6'b1000_01 : 6'b1100_00)) begin
          errors++;
          $display("FAIL abort_timing cycle %0d: gate/dead got %b/%b", i, o_gate, o_dead);
        end
      end
    end
    checks++;
    if (hi_seen) begin
      errors++;
      $display("FAIL abort_high_gate: high gate got 1 expected never");
    end
  endtask

  task automatic test_random();
    int hold = 0;
    logic last_ill = 1'b0;
    logic [3:0] p;
    for (int i = 1; i <= 1500; i++) begin
      if (hold == 0) begin
        p = 4'($urandom_range(0, 15));
        if (last_ill && ((p[0] & p[2]) | (p[1] & p[3]))) p = p & 4'b0011;
        last_ill = (p[0] & p[2]) | (p[1] & p[3]);
        hold = last_ill ? int'($urandom_range(1, 2)) : int'($urandom_range(1, 40));
        mosfet = p;
        dt = 8'($urandom_range(0, 30));
        en = $urandom_range(0, 9) != 0;
      end
      hold--;
      @(negedge clk);
      checks++;
      if ({o_gate, o_dead, o_fault} !== {m_gate, m_dead, m_fault}) begin
        errors++;
        $display("FAIL random_model cycle %0d: got %b/%b/%b expected %b/%b/%b", i, o_gate, o_dead, o_fault, m_gate, m_dead, m_fault);
      end
      checks++;
      if ((o_gate[0] && o_gate[2]) || (o_gate[1] && o_gate[3])) begin
        errors++;
        $display("FAIL random_overlap cycle %0d: gate %b", i, o_gate);
      end
    end
  endtask

  task automatic test_fault();
    en = 1'b1; dt = 8'd12; mosfet = 4'b0000;
    repeat (3) @(negedge clk);
    mosfet = 4'b0101;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      checks++;
      if ({o_gate, o_dead, o_fault} !== {m_gate, m_dead, m_fault}) begin
        errors++;
        $display("FAIL fault_model cycle %0d: got %b/%b/%b expected %b/%b/%b", i, o_gate, o_dead, o_fault, m_gate, m_dead, m_fault);
      end
      checks++;
      if (i < 5 ? o_fault !== 1'b0 : {o_gate, o_fault} !== 5'b0000_1) begin
        errors++;
        $display("FAIL fault_latch cycle %0d: gate/fault got %b/%b", i, o_gate, o_fault);
      end
      if (i == 4) mosfet = 4'b1001;
    end
  endtask

  task automatic test_async_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; dt = 8'd15; mosfet = 4'b0110;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++;
      if ({o_gate, o_dead, o_fault} !== {m_gate, m_dead, m_fault}) begin
        errors++;
        $display("FAIL arst_pre_model cycle %0d: got %b/%b/%b expected %b/%b/%b", i, o_gate, o_dead, o_fault, m_gate, m_dead, m_fault);
      end
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_gate, o_dead, o_fault} !== 7'b0) begin
      errors++;
      $display("FAIL arst_mid_dead: got %b expected 0000000", {o_gate, o_dead, o_fault});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      checks++;
      if ({o_gate, o_dead, o_fault} !== {m_gate, m_dead, m_fault}) begin
        errors++;
        $display("FAIL arst_post_model cycle %0d: got %b/%b/%b expected %b/%b/%b", i, o_gate, o_dead, o_fault, m_gate, m_dead, m_fault);
      end
      if (i == 16 || i == 17) begin
        checks++;
        if ({o_gate, o_dead} !== ((i == 16) ? 6'b0000_11 : 6'b0110_00)) begin
          errors++;
          $display("FAIL arst_first_gate cycle %0d: gate/dead got %b/%b", i, o_gate, o_dead);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_enable_start();
    test_commutation();
    test_clamp();
    test_abort();
    test_random();
    test_fault();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
